hazard_fwd_unit: RTL and testbench

- Parametrised hazard and forwarding unit for the xgriscv in-order pipeline.
- Tracks in-flight register writers from E through W in an internal shift array.
- Resolves rs1/rs2 operands for the instruction in D from the youngest ready producer.
- Generates load-use stalls and bubbles, honours branch flush and an external pipeline hold, and keeps a saturating stall-cycle counter.
- Sits beside the datapath: its stall output drives the PC/IF-ID enables, and its resolved operands feed the ID/EX registers.

---
 rtl/hazard_fwd_unit_if.sv | 40 ++++
 rtl/hazard_fwd_unit.sv | 103 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// D-stage operand/hazard bus between the datapath (master) and hazard_fwd_unit (slave).
// Purely combinational request/response; stall is the only backpressure, and it is level-based.
interface hazard_fwd_unit_if #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int NSTAGES     = 3,
  parameter int SELW        = $clog2(NSTAGES + 1)
);
  logic                     validD;
  logic [RFIDX_WIDTH-1:0]   rs1D;
  logic [RFIDX_WIDTH-1:0]   rs2D;
  logic                     use_rs1D;
  logic                     use_rs2D;
  logic [RFIDX_WIDTH-1:0]   rdD;
  logic                     regwriteD;
  logic                     memtoregD;
  logic                     flush;
  logic                     hold;
  logic [XLEN-1:0]          rdata1D;
  logic [XLEN-1:0]          rdata2D;
  logic [NSTAGES*XLEN-1:0]  stage_res;
  logic [XLEN-1:0]          opaD;
  logic [XLEN-1:0]          opbD;
  logic [SELW-1:0]          fwd_a_sel;
  logic [SELW-1:0]          fwd_b_sel;
  logic                     stall;
  logic [31:0]              stall_cnt;

  modport master (
    output validD, rs1D, rs2D, use_rs1D, use_rs2D, rdD, regwriteD, memtoregD,
    output flush, hold, rdata1D, rdata2D, stage_res,
    input  opaD, opbD, fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );

  modport slave (
    input  validD, rs1D, rs2D, use_rs1D, use_rs2D, rdD, regwriteD, memtoregD,
    input  flush, hold, rdata1D, rdata2D, stage_res,
    output opaD, opbD, fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: tracks E..W writers, forwards D operands with zero latency.
// Backpressure: combinational stall on load-use (or hold); a stall inserts an E bubble.
module hazard_fwd_unit #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int NSTAGES     = 3,
  parameter int LOAD_READY  = 2,
  parameter int SELW        = $clog2(NSTAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  hazard_fwd_unit_if.slave   bus
);

  typedef struct packed {
    logic                   valid;
    logic [RFIDX_WIDTH-1:0] rd;
    logic                   regwrite;
    logic                   isload;
  } entry_t;

  entry_t [NSTAGES-1:0] inflight;
  entry_t               newEntry;
  logic [31:0]          stallCnt;
  logic [NSTAGES-1:0]   readyVec;
  logic [XLEN-1:0]      stageRes [NSTAGES];
  logic                 coreStall;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_slice
    assign stageRes[k] = bus.stage_res[k*XLEN +: XLEN];
  end

  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      readyVec[k] = !inflight[k].isload || (k >= LOAD_READY);
    end
  end

  // One resolver per source operand: isolate the youngest match, then mux.
  for (genvar op = 0; op < 2; op++) begin : g_op
    logic [RFIDX_WIDTH-1:0] rs;
    logic                   useRs;
    logic [XLEN-1:0]        rfData;
    logic [NSTAGES-1:0]     hit;
    logic [NSTAGES-1:0]     first;
    logic [SELW-1:0]        sel;
    logic [XLEN-1:0]        data;
    logic                   haz;

    assign rs     = (op == 0) ? bus.rs1D     : bus.rs2D;
    assign useRs  = (op == 0) ? bus.use_rs1D : bus.use_rs2D;
    assign rfData = (op == 0) ? bus.rdata1D  : bus.rdata2D;

    always_comb begin
      for (int k = 0; k < NSTAGES; k++) begin
        hit[k] = useRs && (rs != '0) && inflight[k].valid &&
                 inflight[k].regwrite && (inflight[k].rd == rs);
      end
    end

    assign first = hit & (~hit + NSTAGES'(1));
    assign haz   = |(first & ~readyVec);

    always_comb begin
      sel  = '0;
      data = rfData;
      for (int k = 0; k < NSTAGES; k++) begin
        if (first[k] && readyVec[k]) begin
          sel  = SELW'(k + 1);
          data = stageRes[k];
        end
      end
    end
  end

  assign coreStall = bus.validD && !bus.flush && (g_op[0].haz || g_op[1].haz);

  assign bus.stall     = coreStall || bus.hold;
  assign bus.fwd_a_sel = g_op[0].sel;
  assign bus.fwd_b_sel = g_op[1].sel;
  assign bus.opaD      = g_op[0].data;
  assign bus.opbD      = g_op[1].data;
  assign bus.stall_cnt = stallCnt;

  assign newEntry.valid    = bus.validD && !coreStall && !bus.flush;
  assign newEntry.rd       = bus.rdD;
  assign newEntry.regwrite = bus.regwriteD;
  assign newEntry.isload   = bus.memtoregD;

  // hold freezes everything, including flush sampling; reset overrides hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      stallCnt <= '0;
    end else if (!bus.hold) begin
      inflight <= {inflight[NSTAGES-2:0], newEntry};
      if (coreStall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the in-flight writers.
module tb_hazard_fwd_unit;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NS   = 3;
  localparam int LR   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .NSTAGES(NS)) bus();

  hazard_fwd_unit #(
    .XLEN(XLEN), .RFIDX_WIDTH(RW), .NSTAGES(NS), .LOAD_READY(LR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [XLEN-1:0] sr [NS];
  always_comb begin
    for (int k = 0; k < NS; k++) bus.stage_res[k*XLEN +: XLEN] = sr[k];
  end

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } mrec_t;

  mrec_t       mq[$];      // index 0 = youngest (E)
  int unsigned mCnt = 0;
  bit          chkOn = 1'b0;
  int          passCnt = 0;
  int          checkCnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Youngest producer of rs decides: forwardable -> its stage result, not yet -> hazard.
  function automatic void mRes(input bit useRs, input int rs, input logic [31:0] rf,
                               output int sel, output logic [31:0] val, output bit haz);
    int k;
    sel = 0; val = rf; haz = 1'b0;
    if (!useRs || rs == 0) return;
    k = 0;
    while (k < mq.size() && !(mq[k].valid && mq[k].wr && mq[k].rd == rs)) k++;
    if (k == mq.size()) return;
    if (mq[k].ld && k < LR) haz = 1'b1;
    else begin
      sel = k + 1;
      val = sr[k];
    end
  endfunction

  function automatic bit mCoreStall();
    int s; logic [31:0] v; bit ha, hb;
    mRes(bus.use_rs1D, int'(bus.rs1D), bus.rdata1D, s, v, ha);
    mRes(bus.use_rs2D, int'(bus.rs2D), bus.rdata2D, s, v, hb);
    return bus.validD && !bus.flush && (ha || hb);
  endfunction

  initial begin : model
    bit    s;
    mrec_t r;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        for (int k = 0; k < NS; k++) mq.push_back('{1'b0, 0, 1'b0, 1'b0});
        mCnt  = 0;
        chkOn = 1'b1;
      end else if (!bus.hold) begin
        s = mCoreStall();
        if (s && mCnt != 32'hFFFF_FFFF) mCnt++;
        r = '{bus.validD && !s && !bus.flush, int'(bus.rdD), bus.regwriteD, bus.memtoregD};
        mq.push_front(r);
        void'(mq.pop_back());
      end
    end
  end

  initial begin : cmp
    int sa, sb; logic [31:0] va, vb; bit ha, hb;
    forever begin
      @(negedge clk);
      if (chkOn) begin
        mRes(bus.use_rs1D, int'(bus.rs1D), bus.rdata1D, sa, va, ha);
        mRes(bus.use_rs2D, int'(bus.rs2D), bus.rdata2D, sb, vb, hb);
        chk("m_stall", bus.stall, (bus.validD && !bus.flush && (ha || hb)) || bus.hold);
        chk("m_cnt", bus.stall_cnt, mCnt);
        if (!ha) begin
          chk("m_sel_a", bus.fwd_a_sel, sa);
          chk("m_opa", bus.opaD, va);
        end
        if (!hb) begin
          chk("m_sel_b", bus.fwd_b_sel, sb);
          chk("m_opb", bus.opbD, vb);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input bit ld);
    bus.validD    = v;
    bus.rs1D      = RW'(rs1);
    bus.use_rs1D  = u1;
    bus.rs2D      = RW'(rs2);
    bus.use_rs2D  = u2;
    bus.rdD       = RW'(rd);
    bus.regwriteD = wr;
    bus.memtoregD = ld;
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin : stim
    reset = 1'b0;
    setD(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush   = 1'b0;
    bus.hold    = 1'b0;
    bus.rdata1D = 32'h0;
    bus.rdata2D = 32'h0;
    for (int k = 0; k < NS; k++) sr[k] = 32'h0;
    step();

    // reset state
    doReset();
    bus.rdata1D = 32'hA5A5_0001;
    setD(1, 3, 1, 4, 1, 6, 1, 0);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_opa", bus.opaD, 32'hA5A5_0001);

    // ALU producer in E forwards immediately
    doReset();
    setD(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    sr[0] = 32'h0000_0007;
    setD(1, 5, 1, 0, 0, 9, 1, 0);
    #1;
    chk("t1_sel_a", bus.fwd_a_sel, 1);
    chk("t1_opa", bus.opaD, 32'h0000_0007);
    chk("t1_stall", bus.stall, 0);

    // load-use: two stall cycles, then forward from W
    doReset();
    sr[2] = 32'hDEAD_BEEF;
    setD(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    setD(1, 5, 1, 0, 1, 7, 1, 0);
    #1;
    chk("t2_stall0", bus.stall, 1);
    step();
    chk("t2_stall1", bus.stall, 1);
    chk("t2_cnt1", bus.stall_cnt, 1);
    step();
    chk("t2_stall2", bus.stall, 0);
    chk("t2_sel_a", bus.fwd_a_sel, 3);
    chk("t2_opa", bus.opaD, 32'hDEAD_BEEF);
    chk("t2_cnt2", bus.stall_cnt, 2);

    // x0 is never forwarded
    doReset();
    setD(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    bus.rdata1D = 32'h0;
    sr[0] = 32'h0000_0055;
    setD(1, 0, 1, 0, 0, 3, 1, 0);
    #1;
    chk("t3_sel_a", bus.fwd_a_sel, 0);
    chk("t3_opa", bus.opaD, 0);
    chk("t3_stall", bus.stall, 0);

    // youngest of two writers wins
    doReset();
    setD(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    step();
    sr[0] = 32'h11;
    sr[1] = 32'h22;
    setD(1, 5, 1, 5, 1, 8, 1, 0);
    #1;
    chk("t4_sel_a", bus.fwd_a_sel, 1);
    chk("t4_sel_b", bus.fwd_b_sel, 1);
    chk("t4_opa", bus.opaD, 32'h11);
    chk("t4_opb", bus.opbD, 32'h11);

    // flush beats a load-use hazard and kills D
    doReset();
    setD(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    setD(1, 5, 1, 0, 0, 7, 1, 0);
    bus.flush = 1'b1;
    #1;
    chk("t5_stall_flush", bus.stall, 0);
    step();
    bus.flush = 1'b0;
    setD(1, 5, 1, 7, 1, 9, 1, 0);
    #1;
    chk("t5_load_in_m", bus.stall, 1);
    chk("t5_sel_b", bus.fwd_b_sel, 0);
    chk("t5_cnt", bus.stall_cnt, 0);

    // hold freezes a load-use stall, then reset mid-stall
    doReset();
    setD(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    setD(1, 5, 1, 0, 0, 7, 1, 0);
    bus.rdata1D = 32'h0000_1234;
    #1;
    chk("t6_stall", bus.stall, 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold_stall", bus.stall, 1);
      chk("t6_hold_cnt", bus.stall_cnt, 0);
    end
    bus.hold = 1'b0;
    #1;
    chk("t6_frozen", bus.stall, 1);
    step();
    chk("t6_cnt1", bus.stall_cnt, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_rst_stall", bus.stall, 0);
    chk("t6_rst_cnt", bus.stall_cnt, 0);
    chk("t6_rst_sel_a", bus.fwd_a_sel, 0);
    chk("t6_rst_opa", bus.opaD, 32'h0000_1234);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(199) == 0);
      bus.flush   = ($urandom_range(9) == 0);
      bus.hold    = ($urandom_range(9) == 0);
      bus.rdata1D = $urandom();
      bus.rdata2D = $urandom();
      for (int k = 0; k < NS; k++) sr[k] = $urandom();
      setD($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
           $urandom_range(1), $urandom_range(7), $urandom_range(3) != 0, $urandom_range(2) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
